// File: rtl/uart_mem_pkg.sv
// Shared constants and FSM state encoding for the UART burst memory controller.
package uart_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_WDATA,
    ST_RFETCH,
    ST_RSEND,
    ST_ACK,
    ST_CSUM
  } state_e;

endpackage

// File: rtl/burst_ram.sv
// Single-port byte RAM: synchronous write, registered read, array not reset.
module burst_ram #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o
);

  logic [7:0] mem_q [0:(2**ADDR_WIDTH)-1];

  // Write on enable; read data is registered (old contents on a same-address write).
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/uart_burst_memory.sv
// UART-driven burst read/write controller around burst_ram.
// Optional feature macro: UART_MEM_CHECKSUM_EN (appends an XOR checksum byte
// after each read burst and after each write ACK).
module uart_burst_memory
  import uart_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       tx_busy,
  output logic       transmit,
  output logic [7:0] tx_byte,
  output logic       busy
);

  localparam int unsigned ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            abyte_q, abyte_d;
  logic [7:0]            rem_q, rem_d;
  logic                  wr_q, wr_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  transmit_q, transmit_d;
  logic [7:0]            txb_q, txb_d;
`ifdef UART_MEM_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic                  ram_we;
  logic [7:0]            ram_rdata;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic                  tx_ok;
  logic                  in_cmd;
  logic                  tmo_exp;

  // Address bytes arrive MSB first; bits above ADDR_WIDTH fall off the top.
  if (ADDR_WIDTH > 8) begin : g_wide
    assign addr_shift = {addr_q[ADDR_WIDTH-9:0], rx_byte};
  end else begin : g_narrow
    assign addr_shift = rx_byte[ADDR_WIDTH-1:0];
  end

  // One idle cycle after every strobe gives the UART time to raise tx_busy.
  assign tx_ok    = !tx_busy && !transmit_q;
  assign in_cmd   = (state_q == ST_ADDR) || (state_q == ST_LEN) || (state_q == ST_WDATA);
  assign tmo_exp  = (tmo_q == TW'(TIMEOUT_CYCLES));
  assign transmit = transmit_q;
  assign tx_byte  = txb_q;
  assign busy     = (state_q != ST_IDLE);

  burst_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (addr_q),
    .wdata_i (rx_byte),
    .rdata_o (ram_rdata)
  );

  // Next-state, datapath and response selection.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    abyte_d    = abyte_q;
    rem_d      = rem_q;
    wr_d       = wr_q;
    tmo_d      = '0;
    transmit_d = 1'b0;
    txb_d      = txb_q;
    ram_we     = 1'b0;
`ifdef UART_MEM_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    if (in_cmd && !received && (TIMEOUT_CYCLES != 0)) begin
      if (tmo_exp) state_d = ST_IDLE;
      else         tmo_d   = tmo_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (received) begin
          abyte_d = '0;
`ifdef UART_MEM_CHECKSUM_EN
          csum_d  = '0;
`endif
          if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
            wr_d    = (rx_byte == CMD_WRITE);
            state_d = ST_ADDR;
          end else if (!tx_busy) begin
            transmit_d = 1'b1;
            txb_d      = RSP_NAK;
          end
        end
      end
      ST_ADDR: begin
        if (received) begin
          addr_d  = addr_shift;
          abyte_d = abyte_q + 2'd1;
          if (abyte_q == 2'(ADDR_BYTES - 1)) state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (received) begin
          rem_d   = rx_byte;
          state_d = wr_q ? ST_WDATA : ST_RFETCH;
        end
      end
      ST_WDATA: begin
        if (received) begin
          ram_we = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
`ifdef UART_MEM_CHECKSUM_EN
          csum_d = csum_q ^ rx_byte;
`endif
          if (rem_q == 8'd0) state_d = ST_ACK;
          else               rem_d   = rem_q - 8'd1;
        end
      end
      ST_RFETCH: state_d = ST_RSEND;
      ST_RSEND: begin
        if (tx_ok) begin
          transmit_d = 1'b1;
          txb_d      = ram_rdata;
          addr_d     = addr_q + ADDR_WIDTH'(1);
`ifdef UART_MEM_CHECKSUM_EN
          csum_d     = csum_q ^ ram_rdata;
`endif
          if (rem_q == 8'd0) begin
`ifdef UART_MEM_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            rem_d   = rem_q - 8'd1;
            state_d = ST_RFETCH;
          end
        end
      end
      ST_ACK: begin
        if (tx_ok) begin
          transmit_d = 1'b1;
          txb_d      = RSP_ACK;
`ifdef UART_MEM_CHECKSUM_EN
          state_d    = ST_CSUM;
`else
          state_d    = ST_IDLE;
`endif
        end
      end
      ST_CSUM: begin
`ifdef UART_MEM_CHECKSUM_EN
        if (tx_ok) begin
          transmit_d = 1'b1;
          txb_d      = csum_q;
          state_d    = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      abyte_q    <= '0;
      rem_q      <= '0;
      wr_q       <= 1'b0;
      tmo_q      <= '0;
      transmit_q <= 1'b0;
      txb_q      <= '0;
`ifdef UART_MEM_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      abyte_q    <= abyte_d;
      rem_q      <= rem_d;
      wr_q       <= wr_d;
      tmo_q      <= tmo_d;
      transmit_q <= transmit_d;
      txb_q      <= txb_d;
`ifdef UART_MEM_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_burst_memory.sv
// Directed self-checking bench for uart_burst_memory (TIMEOUT_CYCLES=50).
module tb_uart_burst_memory;
  import uart_mem_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       received;
  logic [7:0] rx_byte;
  logic       tx_busy;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       busy;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   viol     = 0;
  bq_t  rxq;
  int   stamps[$];

  uart_burst_memory #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(50)) dut (
    .clk      (clk),
    .reset    (reset),
    .received (received),
    .rx_byte  (rx_byte),
    .tx_busy  (tx_busy),
    .transmit (transmit),
    .tx_byte  (tx_byte),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every transmit strobe away from the active edge.
  always @(negedge clk) begin
    if (transmit === 1'b1) begin
      rxq.push_back(tx_byte);
      stamps.push_back(cyc);
      if (tx_busy === 1'b1) viol++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    received = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    received = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_rx();
    rxq.delete();
    stamps.delete();
  endtask

  // Wait for n strobes (bounded), then a quiet window to catch extras.
  task automatic wait_rx(input string tag, input int n, input int budget);
    int k = 0;
    while (rxq.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (12) @(posedge clk);
    chk({tag, "_count"}, rxq.size(), n);
  endtask

  task automatic check_stream(input string tag, input bq_t exp);
    wait_rx(tag, exp.size(), 3000);
    for (int i = 0; i < exp.size(); i++)
      if (i < rxq.size()) chk($sformatf("%s[%0d]", tag, i), rxq[i], exp[i]);
  endtask

  function automatic bq_t with_csum(input bq_t head, input bq_t data);
    bq_t r = head;
`ifdef UART_MEM_CHECKSUM_EN
    logic [7:0] x = '0;
    foreach (data[i]) x ^= data[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr, input int n);
    send(cmd);
    send(addr[15:8]);
    send(addr[7:0]);
    send(8'(n - 1));
  endtask

  task automatic do_write(input string tag, input logic [15:0] addr, input bq_t d);
    bq_t ack;
    clear_rx();
    send_hdr(CMD_WRITE, addr, d.size());
    foreach (d[i]) send(d[i]);
    ack = '{RSP_ACK};
    check_stream(tag, with_csum(ack, d));
    clear_rx();
  endtask

  task automatic do_read(input string tag, input logic [15:0] addr, input bq_t d);
    clear_rx();
    send_hdr(CMD_READ, addr, d.size());
    check_stream(tag, with_csum(d, d));
    clear_rx();
  endtask

  initial begin
    bq_t d;
    bq_t e;
    int  k;
    reset    = 1'b1;
    received = 1'b0;
    rx_byte  = 8'h00;
    tx_busy  = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_transmit", transmit, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Write then read a single byte.
    d = '{8'h5A};
    do_write("wr_single", 16'h0123, d);
    chk("wr_single_idle", busy, 1'b0);
    do_read("rd_single", 16'h0123, d);

    // Burst wrapping past the top of memory.
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write("wr_wrap", 16'h03FE, d);
    do_read("rd_wrap", 16'h03FE, d);
    d = '{8'h33, 8'h44};
    do_read("rd_low", 16'h0000, d);

    // Unknown command answered with NAK; controller stays idle.
    clear_rx();
    send(8'h7E);
    chk("nak_busy", busy, 1'b0);
    e = '{RSP_NAK};
    check_stream("nak", e);
    clear_rx();
    d = '{8'h5A};
    do_read("rd_after_nak", 16'h0123, d);

    // Backpressure: tx_busy held high across a 4-byte read.
    clear_rx();
    @(posedge clk); #1;
    tx_busy = 1'b1;
    send_hdr(CMD_READ, 16'h03FE, 4);
    repeat (500) @(posedge clk);
    chk("bp_held_count", rxq.size(), 0);
    chk("bp_held_busy", busy, 1'b1);
    #1;
    tx_busy = 1'b0;
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_stream("bp", with_csum(d, d));
    for (int i = 1; i < stamps.size(); i++)
      chk($sformatf("bp_gap%0d", i), (stamps[i] - stamps[i-1]) >= 2, 1'b1);
    chk("bp_no_tx_while_busy", viol, 0);
    clear_rx();

    // Timeout mid-command leaves memory untouched and sends nothing.
    d = '{8'hA7};
    do_write("wr_pre_tmo", 16'h0010, d);
    send(CMD_WRITE);
    send(8'h01);
    repeat (60) @(posedge clk);
    #1;
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_no_tx", rxq.size(), 0);
    do_read("rd_after_tmo", 16'h0010, d);

    // Async reset part-way through an 8-byte read.
    d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    do_write("wr_rst", 16'h0100, d);
    clear_rx();
    send_hdr(CMD_READ, 16'h0100, 8);
    k = 0;
    while (rxq.size() < 3 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("rst_mid_seen3", rxq.size(), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_transmit", transmit, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    repeat (50) @(posedge clk);
    chk("rst_mid_no_more", rxq.size(), 3);
    if (rxq.size() >= 3) begin
      chk("rst_mid_b0", rxq[0], 8'hA0);
      chk("rst_mid_b2", rxq[2], 8'hA2);
    end
    do_read("rd_after_rst", 16'h0100, d);

    chk("no_tx_while_busy", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
